sdram_cpu_bridge: RTL and testbench

- Adapts the 8-bit Oric CPU/ULA memory bus to one 16-bit toggle-handshake port (req/ack, word address [23:1], byte strobes) of the dual-port SDRAM controller.
- Sits directly upstream of that controller's port1 or port2.
- Performs byte-lane selection and write data replication.
- Holds a one-word read cache so repeated accesses within the same 16-bit word do not consume SDRAM slots.

---
 rtl/sdram_cpu_bridge.sv | 144 ++++++++++++++
 tb/tb_sdram_cpu_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cpu_bridge.sv
// Bridges the 8-bit Oric CPU/ULA bus onto one 16-bit toggle-handshake SDRAM controller port,
// with byte-lane steering, write data replication and a one-word read cache.
module sdram_cpu_bridge #(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [22:0] BASE     = 23'h000000,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ready,
    output logic              busy,
    output logic              sd_req,
    input  logic              sd_ack,
    output logic              sd_we,
    output logic [22:0]       sd_a,
    output logic [1:0]        sd_ds,
    output logic [15:0]       sd_d,
    input  logic [15:0]       sd_q
);

    typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

    state_e      state_q, state_d;
    logic        sd_req_q = 1'b0;
    logic        sd_req_d;
    logic        sd_we_q, sd_we_d;
    logic [22:0] sd_a_q, sd_a_d;
    logic [1:0]  sd_ds_q, sd_ds_d;
    logic [15:0] sd_d_q, sd_d_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic [15:0] cache_q, cache_d;
    logic [22:0] tag_q, tag_d;
    logic        valid_q, valid_d;

    logic [22:0] cpu_word;
    logic        sd_done;
    logic        read_hit;

    // Word address wraps modulo 2^23 by truncation of the sum.
    assign cpu_word = BASE + 23'(cpu_addr[ADDR_W-1:1]);
    assign sd_done  = (sd_ack == sd_req_q);
    assign read_hit = CACHE_EN && !cpu_we && valid_q && (tag_q == cpu_word);

    always_comb begin
        state_d     = state_q;
        sd_req_d    = sd_req_q;
        sd_we_d     = sd_we_q;
        sd_a_d      = sd_a_q;
        sd_ds_d     = sd_ds_q;
        sd_d_d      = sd_d_q;
        cpu_dout_d  = cpu_dout_q;
        cpu_ready_d = 1'b0;
        cache_d     = cache_q;
        tag_d       = tag_q;
        valid_d     = valid_q;

        case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    if (read_hit) begin
                        cpu_dout_d  = cpu_addr[0] ? cache_q[15:8] : cache_q[7:0];
                        cpu_ready_d = 1'b1;
                    end else begin
                        sd_a_d   = cpu_word;
                        sd_ds_d  = cpu_addr[0] ? 2'b10 : 2'b01;
                        sd_we_d  = cpu_we;
                        sd_d_d   = {cpu_din, cpu_din};
                        sd_req_d = ~sd_req_q;
                        state_d  = StWait;
                    end
                end
            end
            StWait: begin
                if (sd_done) begin
                    state_d     = StIdle;
                    cpu_ready_d = 1'b1;
                    if (!sd_we_q) begin
                        cpu_dout_d = sd_ds_q[1] ? sd_q[15:8] : sd_q[7:0];
                        if (CACHE_EN) begin
                            cache_d = sd_q;
                            tag_d   = sd_a_q;
                            valid_d = 1'b1;
                        end
                    end else if (CACHE_EN && valid_q && (tag_q == sd_a_q)) begin
                        // Keep the cached word coherent with the byte just written.
                        if (sd_ds_q[1]) begin
                            cache_d[15:8] = sd_d_q[15:8];
                        end else begin
                            cache_d[7:0] = sd_d_q[7:0];
                        end
                    end
                end
            end
            StDrain: begin
                if (sd_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // A request left in flight across reset must be absorbed, not reported.
            state_q     <= (sd_req_q != sd_ack) ? StDrain : StIdle;
            sd_we_q     <= 1'b0;
            sd_a_q      <= '0;
            sd_ds_q     <= 2'b00;
            sd_d_q      <= '0;
            cpu_dout_q  <= '0;
            cpu_ready_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sd_req_q    <= sd_req_d;
            sd_we_q     <= sd_we_d;
            sd_a_q      <= sd_a_d;
            sd_ds_q     <= sd_ds_d;
            sd_d_q      <= sd_d_d;
            cpu_dout_q  <= cpu_dout_d;
            cpu_ready_q <= cpu_ready_d;
            cache_q     <= cache_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
        end
    end

    assign cpu_dout  = cpu_dout_q;
    assign cpu_ready = cpu_ready_q;
    assign busy      = (state_q != StIdle);
    assign sd_req    = sd_req_q;
    assign sd_we     = sd_we_q;
    assign sd_a      = sd_a_q;
    assign sd_ds     = sd_ds_q;
    assign sd_d      = sd_d_q;

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Bench for sdram_cpu_bridge: a cached instance (BASE=0) and an uncached instance (BASE=7FFFFF),
// each behind a toggle-handshake SDRAM model, checked against a byte-level memory/cache model.
module tb_sdram_cpu_bridge;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [15:0] cpu_addr  [2];
    logic [7:0]  cpu_din   [2];
    logic [7:0]  cpu_dout  [2];
    logic        cpu_ready [2];
    logic        busy      [2];
    logic        sd_req    [2];
    logic        sd_ack    [2] = '{1'b0, 1'b0};
    logic        sd_we     [2];
    logic [22:0] sd_a      [2];
    logic [1:0]  sd_ds     [2];
    logic [15:0] sd_d      [2];
    logic [15:0] sd_q      [2];

    // SDRAM model state
    int          lat_v   [2] = '{4, 2};
    int          cnt     [2] = '{0, 0};
    int          tog     [2] = '{0, 0};
    int          rdy     [2] = '{0, 0};
    logic        req_d1  [2] = '{1'b0, 1'b0};
    logic [15:0] mem      [2][256];
    logic [15:0] init_val [2][256];
    logic        init_go = 1'b0;

    // Reference model state
    logic [15:0] ref_w  [2][256];
    logic [22:0] base_v [2] = '{23'h000000, 23'h7FFFFF};
    bit          cen    [2] = '{1'b1, 1'b0};
    bit          cvalid [2] = '{1'b0, 1'b0};
    logic [22:0] ctag   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdram_cpu_bridge #(.ADDR_W(16), .BASE(23'h000000), .CACHE_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_din(cpu_din[0]),
        .cpu_dout(cpu_dout[0]), .cpu_ready(cpu_ready[0]), .busy(busy[0]),
        .sd_req(sd_req[0]), .sd_ack(sd_ack[0]), .sd_we(sd_we[0]), .sd_a(sd_a[0]),
        .sd_ds(sd_ds[0]), .sd_d(sd_d[0]), .sd_q(sd_q[0])
    );

    sdram_cpu_bridge #(.ADDR_W(16), .BASE(23'h7FFFFF), .CACHE_EN(1'b0)) dut_nc (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_din(cpu_din[1]),
        .cpu_dout(cpu_dout[1]), .cpu_ready(cpu_ready[1]), .busy(busy[1]),
        .sd_req(sd_req[1]), .sd_ack(sd_ack[1]), .sd_we(sd_we[1]), .sd_a(sd_a[1]),
        .sd_ds(sd_ds[1]), .sd_d(sd_d[1]), .sd_q(sd_q[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_sd
        always_ff @(posedge clk) begin
            req_d1[g] <= sd_req[g];
            if (sd_req[g] != req_d1[g]) tog[g] <= tog[g] + 1;
            if (cpu_ready[g]) rdy[g] <= rdy[g] + 1;
            if (init_go) begin
                for (int i = 0; i < 256; i++) mem[g][i] <= init_val[g][i];
            end else if (cnt[g] > 1) begin
                cnt[g] <= cnt[g] - 1;
            end else if (cnt[g] == 1) begin
                cnt[g]    <= 0;
                sd_ack[g] <= sd_req[g];
                sd_q[g]   <= mem[g][sd_a[g][7:0]];
                if (sd_we[g] && sd_ds[g][0]) mem[g][sd_a[g][7:0]][7:0]  <= sd_d[g][7:0];
                if (sd_we[g] && sd_ds[g][1]) mem[g][sd_a[g][7:0]][15:8] <= sd_d[g][15:8];
            end else if (sd_req[g] != sd_ack[g]) begin
                cnt[g] <= lat_v[g];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic access(input int g, input bit we, input logic [15:0] addr,
                          input logic [7:0] din);
        logic [22:0] word;
        logic [7:0]  idx;
        bit          hit;
        int          t0, r0, lat;
        word = base_v[g] + 23'(addr >> 1);
        idx  = word[7:0];
        hit  = cen[g] && !we && cvalid[g] && (ctag[g] == word);
        t0   = tog[g];
        r0   = rdy[g];
        @(negedge clk);
        cpu_req[g]  = 1'b1;
        cpu_we[g]   = we;
        cpu_addr[g] = addr;
        cpu_din[g]  = din;
        @(negedge clk);
        cpu_req[g] = 1'b0;
        lat = 1;
        if (!hit) begin
            check_eq("sd_a", 32'(sd_a[g]), 32'(word));
            check_eq("sd_ds", 32'(sd_ds[g]), addr[0] ? 32'd2 : 32'd1);
            check_eq("sd_we", 32'(sd_we[g]), 32'(we));
            check_eq("busy_wait", 32'(busy[g]), 32'd1);
            if (we) check_eq("sd_d", 32'(sd_d[g]), 32'({din, din}));
        end
        while (!cpu_ready[g] && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check_eq("ready", 32'(cpu_ready[g]), 32'd1);
        check_eq("busy_done", 32'(busy[g]), 32'd0);
        check_eq("toggles", 32'(tog[g] - t0), hit ? 32'd0 : 32'd1);
        if (hit) check_eq("hit_latency", 32'(lat), 32'd1);
        if (!we) begin
            check_eq("rdata", 32'(cpu_dout[g]),
                     addr[0] ? 32'(ref_w[g][idx][15:8]) : 32'(ref_w[g][idx][7:0]));
        end
        if (we) begin
            if (addr[0]) ref_w[g][idx][15:8] = din;
            else         ref_w[g][idx][7:0]  = din;
        end else if (cen[g]) begin
            cvalid[g] = 1'b1;
            ctag[g]   = word;
        end
        @(negedge clk);
        check_eq("ready_pulse", 32'(cpu_ready[g]), 32'd0);
        check_eq("ready_count", 32'(rdy[g] - r0), 32'd1);
    endtask

    initial begin
        int t0, r0, n;
        for (int g = 0; g < 2; g++) begin
            cpu_req[g] = 1'b0; cpu_we[g] = 1'b0; cpu_addr[g] = '0; cpu_din[g] = '0;
            for (int i = 0; i < 256; i++) init_val[g][i] = 16'($urandom);
        end
        init_val[0][8'h1A][7:0] = 8'hC3;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 256; i++) ref_w[g][i] = init_val[g][i];

        init_go = 1'b1;
        repeat (3) @(negedge clk);
        init_go = 1'b0;
        reset   = 1'b0;

        check_eq("rst_dout", 32'(cpu_dout[0]), 32'd0);
        check_eq("rst_ready", 32'(cpu_ready[0]), 32'd0);
        check_eq("rst_busy", 32'(busy[0]), 32'd0);
        check_eq("rst_sd_we", 32'(sd_we[0]), 32'd0);
        check_eq("rst_sd_a", 32'(sd_a[0]), 32'd0);
        check_eq("rst_sd_ds", 32'(sd_ds[0]), 32'd0);
        check_eq("rst_sd_d", 32'(sd_d[0]), 32'd0);
        check_eq("rst_busy_nc", 32'(busy[1]), 32'd0);

        // Directed sequence: write, miss read, hit read, coherent write-then-hit.
        lat_v[0] = 4;
        access(0, 1'b1, 16'h1235, 8'hA5);
        access(0, 1'b0, 16'h1234, 8'h00);
        check_eq("plan_c3", 32'(cpu_dout[0]), 32'h0C3);
        access(0, 1'b0, 16'h1235, 8'h00);
        check_eq("plan_a5", 32'(cpu_dout[0]), 32'h0A5);
        access(0, 1'b1, 16'h1234, 8'h7E);
        access(0, 1'b0, 16'h1234, 8'h00);
        check_eq("plan_7e", 32'(cpu_dout[0]), 32'h07E);

        // Reset one cycle after a miss is issued: in-flight ack must be drained silently.
        lat_v[0] = 5;
        t0 = tog[0];
        r0 = rdy[0];
        @(negedge clk);
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 16'h1250;
        @(negedge clk);
        cpu_req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cvalid[0] = 1'b0;
        cvalid[1] = 1'b0;
        @(negedge clk);
        check_eq("drain_busy", 32'(busy[0]), 32'd1);
        cpu_req[0] = 1'b1; cpu_addr[0] = 16'h1260;
        @(negedge clk);
        cpu_req[0] = 1'b0;
        n = 0;
        while (busy[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_end", 32'(busy[0]), 32'd0);
        check_eq("drain_toggles", 32'(tog[0] - t0), 32'd1);
        check_eq("drain_no_ready", 32'(rdy[0] - r0), 32'd0);
        access(0, 1'b0, 16'h1250, 8'h00);

        // A second request while the first is in flight must be dropped.
        lat_v[0] = 4;
        t0 = tog[0];
        r0 = rdy[0];
        @(negedge clk);
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 16'h1270;
        @(negedge clk);
        cpu_req[0] = 1'b0;
        @(negedge clk);
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 16'h1280; cpu_din[0] = 8'h55;
        @(negedge clk);
        cpu_req[0] = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("wait_toggles", 32'(tog[0] - t0), 32'd1);
        check_eq("wait_readies", 32'(rdy[0] - r0), 32'd1);
        check_eq("wait_rdata", 32'(cpu_dout[0]), 32'(ref_w[0][8'h38][7:0]));
        cvalid[0] = 1'b1;
        ctag[0]   = 23'h000938;

        // Randomized traffic on a small window so hits and write merges both occur.
        for (int k = 0; k < 40; k++) begin
            int g;
            g = ($urandom_range(0, 3) == 0) ? 1 : 0;
            lat_v[g] = $urandom_range(1, 6);
            access(g, 1'($urandom_range(0, 1)), 16'h1200 | 16'($urandom_range(0, 31)),
                   8'($urandom));
        end

        // Uncached instance: repeated reads always go to SDRAM; address wraps at 2^23.
        lat_v[1] = 2;
        access(1, 1'b0, 16'h1234, 8'h00);
        access(1, 1'b0, 16'h1234, 8'h00);
        access(1, 1'b0, 16'hFFFF, 8'h00);
        check_eq("wrap_sd_a", 32'(sd_a[1]), 32'h007FFE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
